// File: rtl/sine_wave_sweeper.sv
// Avalon-MM master that sweeps the sine generator FCW and reads one sample per step.
// Define SINE_SWEEP_ABORT_EN to let Abort end a sweep early; otherwise Abort is ignored.
module sine_wave_sweeper #(
    parameter int DWELL_W      = 16,
    parameter int DWELL_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic        Start,
    input  logic [7:0]  StartFcw,
    input  logic [7:0]  StopFcw,
    input  logic [7:0]  StepFcw,
    input  logic        Abort,
    output logic        Busy,
    output logic        Done,
    output logic        SampleValid,
    output logic [9:0]  SampleData,
    output logic [7:0]  SampleFcw,
    output logic        M_ChipSelect,
    output logic        M_Write,
    output logic        M_Read,
    output logic [1:0]  M_Address,
    output logic [31:0] M_WriteData,
    input  logic [31:0] M_ReadData,
    input  logic        M_Waitrequest
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_FCW,
        S_WR_RUN,
        S_DWELL,
        S_RD_REQ,
        S_RD_WAIT,
        S_STEP,
        S_WR_STOP,
        S_DONE
    } state_t;

    localparam logic [1:0] ADDR_RUN = 2'd0;
    localparam logic [1:0] ADDR_FCW = 2'd1;
    localparam logic [1:0] ADDR_SIN = 2'd2;
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

    state_t state_q, state_d;

    logic [7:0]         cur_fcw_q, cur_fcw_d;
    logic [7:0]         stop_fcw_q, stop_fcw_d;
    logic [7:0]         step_fcw_q, step_fcw_d;
    logic               first_q, first_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               abort_q, abort_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic [9:0]         sdata_q, sdata_d;
    logic [7:0]         sfcw_q, sfcw_d;

    logic               cs_q, cs_d;
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic [1:0]         addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic               accept;
    logic               abort_req;
    logic [8:0]         next_fcw;
    logic               sweep_end;
    logic               unused_ok;

    assign accept    = cs_q && (wr_q || rd_q) && !M_Waitrequest;
    assign next_fcw  = {1'b0, cur_fcw_q} + {1'b0, step_fcw_q};
    assign sweep_end = (step_fcw_q == 8'd0) || (next_fcw > {1'b0, stop_fcw_q});
    assign unused_ok = ^{M_ReadData[31:10], Abort, abort_q};

`ifdef SINE_SWEEP_ABORT_EN
    logic abort_win;

    // Abort is only honoured in states that can still divert to the stop write.
    always_comb begin
        abort_win = 1'b0;
        unique case (state_q)
            S_WR_FCW, S_WR_RUN, S_DWELL, S_RD_REQ, S_STEP: abort_win = Abort;
            default: abort_win = 1'b0;
        endcase
    end

    assign abort_req = abort_q | abort_win;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cur_fcw_d  = cur_fcw_q;
        stop_fcw_d = stop_fcw_q;
        step_fcw_d = step_fcw_q;
        first_d    = first_q;
        dwell_d    = dwell_q;
        abort_d    = abort_req;
        sdata_d    = sdata_q;
        sfcw_d     = sfcw_q;
        valid_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (Start) begin
                    cur_fcw_d  = StartFcw;
                    stop_fcw_d = StopFcw;
                    step_fcw_d = StepFcw;
                    first_d    = 1'b1;
                    state_d    = S_WR_FCW;
                end
            end
            S_WR_FCW: begin
                if (accept) begin
                    if (abort_req)    state_d = S_WR_STOP;
                    else if (first_q) state_d = S_WR_RUN;
                    else              state_d = S_DWELL;
                end
            end
            S_WR_RUN: begin
                if (accept) begin
                    first_d = 1'b0;
                    state_d = abort_req ? S_WR_STOP : S_DWELL;
                end
            end
            S_DWELL: begin
                if (abort_req)            state_d = S_WR_STOP;
                else if (dwell_q == '0)   state_d = S_RD_REQ;
                else                      dwell_d = dwell_q - 1'b1;
            end
            S_RD_REQ: begin
                if (accept) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // Fixed one-cycle read latency: data is on the bus now.
                sdata_d = M_ReadData[9:0];
                sfcw_d  = cur_fcw_q;
                valid_d = 1'b1;
                state_d = abort_req ? S_WR_STOP : S_STEP;
            end
            S_STEP: begin
                if (abort_req || sweep_end) begin
                    state_d = S_WR_STOP;
                end else begin
                    cur_fcw_d = next_fcw[7:0];
                    state_d   = S_WR_FCW;
                end
            end
            S_WR_STOP: begin
                if (accept) state_d = S_DONE;
            end
            S_DONE: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_DWELL && state_q != S_DWELL) begin
            dwell_d = DWELL_LOAD;
        end
    end

    // Bus strobes are registered from the next state so they hold through stalls.
    always_comb begin
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        addr_d  = ADDR_RUN;
        wdata_d = 32'd0;
        unique case (state_d)
            S_WR_FCW: begin
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = ADDR_FCW;
                wdata_d = {24'd0, cur_fcw_d};
            end
            S_WR_RUN: begin
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = ADDR_RUN;
                wdata_d = 32'd1;
            end
            S_RD_REQ: begin
                cs_d   = 1'b1;
                rd_d   = 1'b1;
                addr_d = ADDR_SIN;
            end
            S_WR_STOP: begin
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = ADDR_RUN;
                wdata_d = 32'd0;
            end
            default: begin
                cs_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= S_IDLE;
            cur_fcw_q  <= 8'd0;
            stop_fcw_q <= 8'd0;
            step_fcw_q <= 8'd0;
            first_q    <= 1'b0;
            dwell_q    <= '0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            sdata_q    <= 10'd0;
            sfcw_q     <= 8'd0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= 2'd0;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cur_fcw_q  <= cur_fcw_d;
            stop_fcw_q <= stop_fcw_d;
            step_fcw_q <= step_fcw_d;
            first_q    <= first_d;
            dwell_q    <= dwell_d;
            abort_q    <= abort_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            sdata_q    <= sdata_d;
            sfcw_q     <= sfcw_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign Busy         = busy_q;
    assign Done         = done_q;
    assign SampleValid  = valid_q;
    assign SampleData   = sdata_q;
    assign SampleFcw    = sfcw_q;
    assign M_ChipSelect = cs_q;
    assign M_Write      = wr_q;
    assign M_Read       = rd_q;
    assign M_Address    = addr_q;
    assign M_WriteData  = wdata_q;

endmodule

// File: tb/tb_sine_wave_sweeper.sv
// Randomised bench for sine_wave_sweeper against a transaction-level sweep model.
// Targets the default build (Abort ignored).
module tb_sine_wave_sweeper;

    localparam int DW = 16;
    localparam int DC = 16;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  StartFcw = 8'd0;
    logic [7:0]  StopFcw = 8'd0;
    logic [7:0]  StepFcw = 8'd0;
    logic        Abort = 1'b0;
    logic        Busy;
    logic        Done;
    logic        SampleValid;
    logic [9:0]  SampleData;
    logic [7:0]  SampleFcw;
    logic        M_ChipSelect;
    logic        M_Write;
    logic        M_Read;
    logic [1:0]  M_Address;
    logic [31:0] M_WriteData;
    logic [31:0] M_ReadData = 32'd0;
    logic        M_Waitrequest = 1'b0;

    sine_wave_sweeper #(.DWELL_W(DW), .DWELL_CYCLES(DC)) dut (
        .Clk(Clk), .ResetN(ResetN), .Start(Start),
        .StartFcw(StartFcw), .StopFcw(StopFcw), .StepFcw(StepFcw),
        .Abort(Abort), .Busy(Busy), .Done(Done),
        .SampleValid(SampleValid), .SampleData(SampleData),
        .SampleFcw(SampleFcw), .M_ChipSelect(M_ChipSelect),
        .M_Write(M_Write), .M_Read(M_Read), .M_Address(M_Address),
        .M_WriteData(M_WriteData), .M_ReadData(M_ReadData),
        .M_Waitrequest(M_Waitrequest)
    );

    always #5 Clk = ~Clk;

    typedef struct { bit w; bit [1:0] a; bit [7:0] d; } txn_t;
    typedef struct { bit [7:0] f; bit [9:0] v; } smp_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    txn_t exp_txn[$];
    smp_t exp_smp[$];
    int   fcws[$];
    int   smp_cyc[$];
    int   rd_idx = 0;
    int   start_cyc = 0;
    int   done_seen = 0;

    bit   m_busy = 0;
    bit   clr_busy = 0;
    bit   chk_en = 0;
    int   done_due = -1;
    int   sv_due = -1;
    int   rd_cyc = -1;
    logic [31:0] rd_val = 32'd0;
    int   wmode = 0;
    int   stall_cnt = 0;
    int   stall_lim = 0;
    bit   prev_stall = 0;
    logic [36:0] prev_vec = '0;
    int   last_wacc = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected bus transactions and sample FCWs for one sweep.
    function automatic void build(input int s, input int e, input int st);
        int f = s;
        exp_txn.delete(); exp_smp.delete(); fcws.delete(); smp_cyc.delete();
        rd_idx = 0;
        while (1) begin
            fcws.push_back(f);
            exp_txn.push_back('{1'b1, 2'd1, 8'(f)});
            if (fcws.size() == 1) exp_txn.push_back('{1'b1, 2'd0, 8'd1});
            exp_txn.push_back('{1'b0, 2'd2, 8'd0});
            if (st == 0 || f + st > e) break;
            f = f + st;
        end
        exp_txn.push_back('{1'b1, 2'd0, 8'd0});
    endfunction

    always @(posedge Clk) begin
        cyc++;
        if (ResetN && Start && !m_busy) begin
            m_busy = 1;
            start_cyc = cyc;
            build(int'(StartFcw), int'(StopFcw), int'(StepFcw));
        end
        if (clr_busy) begin
            m_busy = 0;
            clr_busy = 0;
        end
    end

    // Slave model plus per-cycle comparison.
    always @(negedge Clk) begin
        bit act;
        bit stall;
        txn_t t;
        smp_t s;
        if (ResetN && chk_en) begin
            stall = 0;
            check("busy", Busy, m_busy);
            check("done", Done, cyc == done_due);
            if (Done) done_seen = cyc;
            if (cyc == done_due) begin
                clr_busy = 1;
                check("txn_left", exp_txn.size(), 0);
                check("smp_left", exp_smp.size(), 0);
            end
            check("valid", SampleValid, cyc == sv_due);
            if (SampleValid) begin
                smp_cyc.push_back(cyc);
                if (exp_smp.size() == 0) begin
                    check("smp_extra", 1, 0);
                end else begin
                    s = exp_smp.pop_front();
                    check("smp_fcw", SampleFcw, s.f);
                    check("smp_data", SampleData, s.v);
                end
            end
            if (!m_busy) check("idle_strobe", {M_ChipSelect, M_Write, M_Read}, 0);
            if (M_Write || M_Read) check("cs_with_strobe", M_ChipSelect, 1);
            if (prev_stall) begin
                check("hold", {M_ChipSelect, M_Write, M_Read, M_Address, M_WriteData},
                      prev_vec);
            end
            if (cyc == rd_cyc) M_ReadData = rd_val;
            else               M_ReadData = $urandom();
            act = M_ChipSelect && (M_Write || M_Read);
            if (act) begin
                if (!prev_stall) begin
                    stall_cnt = 0;
                    if (wmode == 0)      stall_lim = 0;
                    else if (wmode == 1) stall_lim = 3;
                    else                 stall_lim = $urandom_range(0, 3);
                    if (M_Read) check("dwell", cyc - last_wacc, DC + 1);
                end
                if (stall_cnt < stall_lim) begin
                    M_Waitrequest = 1'b1;
                    stall_cnt++;
                    stall = 1;
                end else begin
                    M_Waitrequest = 1'b0;
                    if (exp_txn.size() == 0) begin
                        check("txn_extra", 1, 0);
                    end else begin
                        t = exp_txn.pop_front();
                        check("txn_wr", M_Write, t.w);
                        check("txn_addr", M_Address, t.a);
                        if (t.w) check("txn_data", M_WriteData, {24'd0, t.d});
                        if (M_Read) begin
                            rd_val = $urandom();
                            rd_cyc = cyc + 1;
                            sv_due = cyc + 2;
                            s.f = 8'(fcws[rd_idx]);
                            s.v = rd_val[9:0];
                            exp_smp.push_back(s);
                            rd_idx++;
                        end else begin
                            last_wacc = cyc;
                            if (t.a == 2'd0 && t.d == 8'd0) done_due = cyc + 1;
                        end
                    end
                end
            end else begin
                M_Waitrequest = 1'($urandom_range(0, 1));
            end
            prev_stall = stall;
            prev_vec = {M_ChipSelect, M_Write, M_Read, M_Address, M_WriteData};
        end
    end

    task automatic sweep(input int s, input int e, input int st,
                         input int wm, input bit noise, input bit ab);
        bit ok = 0;
        wmode = wm;
        @(negedge Clk);
        StartFcw = 8'(s); StopFcw = 8'(e); StepFcw = 8'(st);
        Start = 1'b1; Abort = ab;
        @(negedge Clk);
        Start = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (Done) begin
                ok = 1;
                break;
            end
            if (noise) begin
                Start = 1'($urandom_range(0, 7) == 0);
                StartFcw = 8'($urandom()); StopFcw = 8'($urandom());
                StepFcw = 8'($urandom()); Abort = 1'($urandom_range(0, 1));
            end
            @(negedge Clk);
        end
        Start = 1'b0; Abort = 1'b0;
        check("sweep_done_timeout", ok, 1);
        @(negedge Clk);
    endtask

    task automatic clear_model();
        m_busy = 0; clr_busy = 0;
        exp_txn.delete(); exp_smp.delete();
        done_due = -1; sv_due = -1; rd_cyc = -1;
        prev_stall = 0; stall_cnt = 0;
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        check("rst_busy", Busy, 0);
        check("rst_strobes", {M_ChipSelect, M_Write, M_Read, Done, SampleValid}, 0);
        check("rst_sample", {SampleData, SampleFcw}, 0);
        ResetN = 1'b1;
        chk_en = 1;
        repeat (2) @(negedge Clk);

        sweep(10, 40, 10, 0, 0, 0);
        check("t1_nsteps", fcws.size(), 4);
        check("t1_fcw0", fcws[0], 10);
        check("t1_fcw3", fcws[3], 40);
        check("t1_nsamp", smp_cyc.size(), 4);
        check("t1_first_lat", smp_cyc[0] - start_cyc, 20);
        check("t1_spacing", smp_cyc[1] - smp_cyc[0], 20);
        check("t1_done_lat", done_seen - smp_cyc[3], 2);

        sweep(250, 255, 10, 0, 0, 0);
        check("t2_nsteps", fcws.size(), 1);
        check("t2_fcw0", fcws[0], 250);

        sweep(10, 40, 10, 1, 0, 0);
        check("t3_nsamp", smp_cyc.size(), 4);
        check("t3_first_lat", smp_cyc[0] - start_cyc, 29);
        check("t3_spacing", smp_cyc[2] - smp_cyc[1], 26);

        sweep(5, 200, 0, 0, 1, 0);
        check("t4_nsteps", fcws.size(), 1);
        check("t4_fcw0", fcws[0], 5);

        sweep(10, 40, 10, 0, 0, 1);
        check("t5_abort_ignored", smp_cyc.size(), 4);

        sweep(100, 20, 7, 2, 0, 0);
        check("t6_rev_nsamp", smp_cyc.size(), 1);

        // Reset in the dwell of the second step.
        wmode = 0;
        @(negedge Clk);
        StartFcw = 8'd10; StopFcw = 8'd40; StepFcw = 8'd10; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int i = 0; i < 100 && smp_cyc.size() == 0; i++) @(negedge Clk);
        repeat (6) @(negedge Clk);
        chk_en = 0;
        #2 ResetN = 1'b0;
        #1;
        check("arst_busy", Busy, 0);
        check("arst_strobes", {M_ChipSelect, M_Write, M_Read, Done, SampleValid}, 0);
        check("arst_bus", {M_Address, M_WriteData}, 0);
        check("arst_sample", {SampleData, SampleFcw}, 0);
        clear_model();
        repeat (3) @(negedge Clk);
        ResetN = 1'b1;
        chk_en = 1;
        @(negedge Clk);
        sweep(30, 60, 15, 0, 0, 0);
        check("t7_nsteps", fcws.size(), 3);
        check("t7_fcw2", fcws[2], 60);
        check("t7_nsamp", smp_cyc.size(), 3);

        for (int k = 0; k < 6; k++) begin
            int st;
            st = (k == 2) ? 0 : int'($urandom_range(3, 40));
            sweep(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), st, 2, 1, 0);
            check("rnd_nsamp", smp_cyc.size(), fcws.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
